// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Sits beside the ALU in EX. MULT/MULTU/DIV/DIVU compute their result at the
// accept edge, hold it in pending registers, and commit it to hi/lo when the
// busy countdown expires. MTHI/MTLO write hi/lo directly when idle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (clears all state)
//   start  in   qualifies mdop for the current EX instruction
//   mdop   in   3-bit op: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//   op1    in   rs operand (dividend / multiplicand / MT source)
//   op2    in   rt operand (divisor / multiplier)
//   busy   out  operation in progress (registered)
//   hi     out  HI register
//   lo     out  LO register
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  // Signed divide returning {remainder, quotient}. Quotient truncates toward
  // zero, remainder follows the dividend's sign. The most-negative / -1 case
  // cannot be represented, so it is pinned to quotient = dividend, rem = 0.
  function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) begin
      return '0;
    end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == {WIDTH{1'b1}}) begin
      return {{WIDTH{1'b0}}, a};
    end else begin
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
    if (b == '0) begin
      return '0;
    end else begin
      return {a % b, a / b};
    end
  endfunction

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [2*WIDTH-1:0] divr_s, divr_u;

  always_comb begin
    prod_s = $signed({{WIDTH{op1[WIDTH-1]}}, op1}) * $signed({{WIDTH{op2[WIDTH-1]}}, op2});
    prod_u = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    divr_s = div_signed(op1, op2);
    divr_u = div_unsigned(op1, op2);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = S_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIV: begin
              {pend_hi_d, pend_lo_d} = divr_s;
              // Divide by zero still burns the full latency but commits nothing.
              pend_wr_d = (op2 != '0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              {pend_hi_d, pend_lo_d} = divr_u;
              pend_wr_d = (op2 != '0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = op1;
            OP_MTLO: lo_d = op1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Any start presented here is dropped; the hazard unit must stall it.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit, successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage. Executes MULT/MULTU/DIV/DIVU over a configurable number of cycles into HI/LO registers. Also handles MTHI/MTLO writes.
- Exposes `busy` so the hazard unit can stall any later MD-class instruction in ID.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits (>=8).
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is an MD op; qualifies mdop.
- mdop  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- op1  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- op2  input  WIDTH  rt operand (divisor / multiplier).
- busy  output  1  operation in progress.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset: on a clk edge with reset=1, the following are cleared to 0: hi, lo, busy, the internal cycle counter and the pending result registers. Reset aborts any in-flight operation; its result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter>0.
- Accept condition: rising edge with start=1, busy=0, reset=0.
- MULT/MULTU accepted:
  - Full 2*WIDTH product is computed from operands captured at that edge: signed for MULT, unsigned for MULTU.
  - It is stored in pending registers.
  - counter := MUL_CYCLES; state goes to RUN.
- DIV/DIVU accepted:
  - Quotient goes to pending LO, remainder to pending HI. Signed for DIV, unsigned for DIVU.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - counter := DIV_CYCLES; state goes to RUN.
- Latency:
  - busy is 1 for exactly N cycles, starting the cycle after acceptance, where N = MUL_CYCLES or DIV_CYCLES.
  - On the edge where counter goes 1->0: hi/lo load the pending values, busy falls, state goes to IDLE.
  - Result is visible on hi/lo in the same cycle busy reads 0.
- RUN: counter decrements by 1 each edge. hi/lo hold their old values until completion.
- MTHI/MTLO with start=1 and busy=0: hi (resp. lo) := op1 at that edge. busy stays 0. The other register is unchanged.
- Any start while busy=1 is ignored. Stalling is the hazard unit's job; it must hold MD instructions in ID while busy. The block does not queue.
- start=1 with mdop NONE/reserved: no state change.
- Divide by zero (op2==0, DIV or DIVU):
  - Runs the full DIV_CYCLES with busy=1.
  - At completion hi and lo are left unchanged.
- Signed overflow (DIV, op1 = most-negative, op2 = -1): lo := most-negative value, hi := 0.
- Completion and a new start on the same edge: impossible, since busy=1 on that edge. The new start is ignored and must be re-presented by the stalled pipeline.
- Reset asserted together with start: reset wins; start is ignored.
- Outputs are pure registers with no combinational path from inputs.
- MFHI/MFLO are served by the datapath reading hi/lo directly.

Test Plan:
- Reset, then MULT op1=0xFFFFFFFE (-2), op2=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with DIVU -> lo=0x7FFFFFFC, hi=0x00000001.
- MTHI op1=0x12345678 at idle -> hi=0x12345678 next cycle, busy stays 0. Then DIV op2=0 -> busy 10 cycles, hi/lo unchanged. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, assert MTLO start 2 cycles later while busy -> MTLO ignored; lo gets the product at completion.
- Start DIV, assert reset in the 4th busy cycle -> next cycle busy=0, hi=lo=0; no later write to hi/lo. Also assert start with reset together -> no operation.
